adc_sample_framer: RTL
======================

# adc_sample_framer

Downstream stage of the `cs5361` serial-audio receiver. It consumes the 8-bit `adcval`/`adcstrobe` sample stream, buffers the samples in a small FIFO, and wraps them into fixed-length frames with a sync byte and a sequence number. Framed bytes go out on a valid/ready byte interface toward the USB FIFO writer (`ft245r_fifo`). The block decouples bursty USB back-pressure from the fixed ADC sample rate and reports lost samples.

## Interface
Parameters:
- `DEPTH`, 16: FIFO depth in samples; a power of 2, range 4..256.
- `FRAME_LEN`, 32: data samples per frame; range 1..256.
- `SYNC_BYTE`, 8'hA5: first byte of every frame.

Ports:
- `clk` in 1: single system clock, the same clock as the receiver and the USB writer.
- `reset` in 1: asynchronous, active-high reset.
- `adcval` in 8: sample from the receiver; sampled only when `adcstrobe`=1.
- `adcstrobe` in 1: one-cycle pulse per new sample. Back-to-back pulses are legal.
- `enable` in 1: 0 causes incoming strobes to be ignored and not counted as drops. The FIFO and framer keep draining.
- `out_data` out 8: byte toward the USB writer.
- `out_valid` out 1: `out_data` holds a byte to send.
- `out_ready` in 1: the consumer accepts the byte. A transfer happens on a clk edge when `out_valid` & `out_ready`.
- `overflow` out 1: sticky flag, set by the first dropped sample, cleared only by `reset`.
- `drop_count` out 8: number of dropped samples, saturating at 8'hFF.
- `fifo_level` out $clog2(DEPTH)+1: current FIFO occupancy, 0..DEPTH.

## Operation
- **FIFO:** circular buffer of DEPTH × 8 with write pointer, read pointer and occupancy counter. Pointers wrap modulo DEPTH.
- **Push:** happens on `adcstrobe` & `enable`. It is accepted if `fifo_level` < DEPTH, or if a pop occurs in the same cycle (a full FIFO with a simultaneous pop accepts the push and the level stays DEPTH).
- **Drop:** a push that is not accepted drops the sample. It sets `overflow` and increments `drop_count` (saturating). FIFO contents are unchanged.
- **Pop:** happens only in state DATA on a transfer.
- **Framer FSM, states IDLE, SYNC, SEQ, DATA:**
  - IDLE: `out_valid`=0. Moves to SYNC on the next edge when `fifo_level` ≠ 0.
  - SYNC: `out_valid`=1, `out_data`=SYNC_BYTE. Moves to SEQ on transfer.
  - SEQ: `out_valid`=1, `out_data`=`seq` (an 8-bit frame counter). Moves to DATA on transfer and clears `idx`.
  - DATA: `out_valid`=(`fifo_level` ≠ 0), `out_data`=FIFO head. Each transfer pops one sample and increments `idx`. The transfer with `idx`=FRAME_LEN-1 increments `seq` (wrapping 8'hFF to 8'h00) and returns to IDLE.
- Once started, a frame always completes with exactly FRAME_LEN data bytes. If the FIFO empties mid-frame, `out_valid` drops and the FSM waits in DATA. No padding bytes are ever inserted.
- Sample values equal to SYNC_BYTE are passed unmodified. There is no escaping.
- `enable` falling mid-frame does not abort the frame. The frame finishes once enough samples are present; samples already in the FIFO are still sent.
- `out_data`=8'h00 whenever `out_valid`=0.

## Timing
- **Reset values:**
  - state IDLE
  - `out_valid`=0, `out_data`=8'h00
  - `overflow`=0, `drop_count`=0, `fifo_level`=0
  - `seq`=0, `idx`=0, pointers 0
- **Reset mid-frame:** the partial frame and FIFO contents are discarded; the next frame starts with `seq`=0.
- **Latency:** with the FIFO empty and IDLE, a strobe sampled at edge N gives `fifo_level`=1 after N. The FSM enters SYNC at edge N+1, so `out_valid`=1 from N+1. With `out_ready` held high:
  - SYNC transfers at edge N+2
  - SEQ transfers at edge N+3
  - the first sample transfers at edge N+4
- **Throughput:** with `out_ready`=1 and data always available, one byte per clk. One idle cycle (IDLE) separates frames.
- **Handshake rules:**
  - `out_valid`, once asserted in SYNC or SEQ, stays asserted with `out_data` stable until the transfer.
  - In DATA, `out_valid` deasserts only when the FIFO is empty.
  - `out_valid` does not depend combinationally on `out_ready`.
- **Update timing:** `fifo_level`, `overflow` and `drop_count` update on the edge of the push, pop or drop.

## Test plan
- **Single frame:** FRAME_LEN=4, DEPTH=16, `out_ready`=1, strobes with 8'h10, 8'h11, 8'h12, 8'h13 every 4 clks. Required output stream: A5, 00, 10, 11, 12, 13. `seq` becomes 1 and `overflow` stays 0.
- **Back-pressure and overflow:** `out_ready`=0, 20 back-to-back strobes with values 0..19, DEPTH=16. Required: `fifo_level`=16, `drop_count`=4, `overflow`=1. After releasing `out_ready`, data bytes are 0..15 in order.
- **Full with simultaneous pop and push:** FIFO full in DATA, `out_ready`=1 and a strobe in the same cycle. Required: the push is accepted, `fifo_level` stays 16 and `drop_count` is unchanged.
- **Starvation mid-frame:** FRAME_LEN=4 and only 2 samples arrive. Required: A5, seq, then two data bytes, after which `out_valid`=0 in DATA. Two more strobes complete the frame and the FSM returns to IDLE.
- **Sequence wrap and reset:** run 257 frames. Required: the seq bytes go 00..FF, 00. Asserting `reset` mid-frame gives all outputs at their reset values immediately, and the next frame carries seq 00.
- **Enable gating:** `enable`=0 during 5 strobes. Required: no pushes, `drop_count` unchanged, and a frame already in progress still completes.

Source files
------------

// File: rtl/adc_sample_framer.sv
// Buffers ADC samples in a small FIFO and emits fixed-length frames
// (sync byte, sequence number, FRAME_LEN samples) on a valid/ready byte port.
module adc_sample_framer #(
  parameter int          DEPTH     = 16,
  parameter int          FRAME_LEN = 32,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [7:0]                 adcval,
  input  logic                       adcstrobe,
  input  logic                       enable,
  output logic [7:0]                 out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       overflow,
  output logic [7:0]                 drop_count,
  output logic [$clog2(DEPTH):0]     fifo_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [7:0] IDX_LAST = 8'(FRAME_LEN - 1);

  // IDLE: no frame | SYNC: sending sync byte | SEQ: sending seq | DATA: sending samples
  typedef enum logic [1:0] {IDLE, SYNC, SEQ, DATA} state_t;

  state_t          state_q, state_d;
  logic [7:0]      mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]   level_q, level_d;
  logic [7:0]      seq_q, seq_d;
  logic [7:0]      idx_q, idx_d;
  logic            ovf_q;
  logic [7:0]      drop_q;
  logic            push_req, push_ok, pop, drop;

  always_comb begin
    state_d   = state_q;
    seq_d     = seq_q;
    idx_d     = idx_q;
    out_valid = 1'b0;
    out_data  = 8'h00;
    case (state_q)
      IDLE: begin
        if (level_q != '0) state_d = SYNC;
      end
      SYNC: begin
        out_valid = 1'b1;
        out_data  = SYNC_BYTE;
        if (out_ready) state_d = SEQ;
      end
      SEQ: begin
        out_valid = 1'b1;
        out_data  = seq_q;
        if (out_ready) begin
          state_d = DATA;
          idx_d   = 8'h00;
        end
      end
      DATA: begin
        if (level_q != '0) begin
          out_valid = 1'b1;
          out_data  = mem_q[rd_ptr_q];
          if (out_ready) begin
            idx_d = idx_q + 8'h01;
            if (idx_q == IDX_LAST) begin
              seq_d   = seq_q + 8'h01;
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign pop      = (state_q == DATA) && out_valid && out_ready;
  assign push_req = adcstrobe && enable;
  assign push_ok  = push_req && ((level_q < LW'(DEPTH)) || pop);
  assign drop     = push_req && !push_ok;

  always_comb begin
    level_d = level_q;
    case ({push_ok, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      seq_q    <= 8'h00;
      idx_q    <= 8'h00;
      ovf_q    <= 1'b0;
      drop_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      seq_q   <= seq_d;
      idx_q   <= idx_d;
      level_q <= level_d;
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
      if (drop) begin
        ovf_q <= 1'b1;
        if (drop_q != 8'hFF) drop_q <= drop_q + 8'h01;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= adcval;
  end

  assign overflow   = ovf_q;
  assign drop_count = drop_q;
  assign fifo_level = level_q;

endmodule
